// File: rtl/conv_window_sched.sv
// conv_window_sched: sequences one feature-map pass through the conv array.
//   clk, rst                 clock, synchronous active-high reset
//   start, cfg_width/height  pass request and feature-map dimensions (sampled in IDLE)
//   stall                    downstream backpressure, blocks new reads in STREAM
//   busy, done, err          pass status; done/err are one-cycle pulses
//   rd_en, rd_row, rd_col    column read request to the feature SRAM
//   rd_data                  column pixels, valid one cycle after rd_en
//   window*                  column stream to the conv array
//   conv_valid_in, out_count result strobe from the array and its running count
module conv_window_sched #(
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned MAX_DIM     = 64,
  parameter int unsigned ROW_GAP     = 3,
  parameter int unsigned DRAIN_MAX   = 64,
  parameter int unsigned DW          = $clog2(MAX_DIM + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DW-1:0]             cfg_width,
  input  logic [DW-1:0]             cfg_height,
  input  logic                      stall,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      rd_en,
  output logic [DW-1:0]             rd_row,
  output logic [DW-1:0]             rd_col,
  input  logic [KERNEL_SIZE*32-1:0] rd_data,
  output logic                      window_valid,
  output logic                      window_new,
  output logic [KERNEL_SIZE*32-1:0] window,
  input  logic                      conv_valid_in,
  output logic [2*DW-1:0]           out_count
);

  localparam int unsigned CW = 2 * DW;
  localparam int unsigned GW = (ROW_GAP > 1) ? $clog2(ROW_GAP) : 1;
  localparam int unsigned TW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_GAP,
    S_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   row_q, row_d;
  logic [DW-1:0]   col_q, col_d;
  logic [DW-1:0]   w_q, w_d;
  logic [DW-1:0]   h_q, h_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [TW-1:0]   drain_q, drain_d;
  logic            busy_d, done_d, err_d, rd_en_d;
  logic            window_valid_d, window_new_d;
  logic [DW-1:0]   rd_row_d, rd_col_d;
  logic [CW-1:0]   out_count_d;
  logic            cfg_ok_c;
  logic [CW-1:0]   expected_c;

  // Pixel data passes straight through; its timing already matches window_valid.
  assign window = rd_data;

  assign cfg_ok_c = (cfg_width  >= DW'(KERNEL_SIZE)) && (cfg_width  <= DW'(MAX_DIM)) &&
                    (cfg_height >= DW'(KERNEL_SIZE)) && (cfg_height <= DW'(MAX_DIM));

  // Number of valid output positions for the latched dimensions.
  assign expected_c = CW'(h_q - DW'(KERNEL_SIZE - 1)) * CW'(w_q - DW'(KERNEL_SIZE - 1));

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    row_d          = row_q;
    col_d          = col_q;
    w_d            = w_q;
    h_d            = h_q;
    gap_d          = gap_q;
    drain_d        = drain_q;
    busy_d         = busy;
    done_d         = 1'b0;
    err_d          = 1'b0;
    rd_en_d        = 1'b0;
    rd_row_d       = rd_row;
    rd_col_d       = rd_col;
    window_valid_d = rd_en;
    window_new_d   = rd_en && (rd_col == '0);
    out_count_d    = out_count;
    if (busy && conv_valid_in) begin
      out_count_d = out_count + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok_c) begin
            w_d         = cfg_width;
            h_d         = cfg_height;
            row_d       = '0;
            col_d       = '0;
            out_count_d = '0;
            busy_d      = 1'b1;
            state_d     = S_STREAM;
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (!stall) begin
          rd_en_d  = 1'b1;
          rd_row_d = row_q;
          rd_col_d = col_q;
          if (col_q == w_q - DW'(1)) begin
            col_d = '0;
            row_d = row_q + DW'(1);
            if (row_q == h_q - DW'(KERNEL_SIZE)) begin
              drain_d = '0;
              state_d = S_DRAIN;
            end else begin
              gap_d   = '0;
              state_d = S_GAP;
            end
          end else begin
            col_d = col_q + DW'(1);
          end
        end
      end
      S_GAP: begin
        // Idle cycles let the array pipeline empty between output rows.
        if (gap_q == GW'(ROW_GAP - 1)) begin
          state_d = S_STREAM;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_DRAIN: begin
        if (out_count >= expected_c) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (drain_q == TW'(DRAIN_MAX - 1)) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          drain_d = drain_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      w_q          <= '0;
      h_q          <= '0;
      gap_q        <= '0;
      drain_q      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      rd_en        <= 1'b0;
      rd_row       <= '0;
      rd_col       <= '0;
      window_valid <= 1'b0;
      window_new   <= 1'b0;
      out_count    <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      w_q          <= w_d;
      h_q          <= h_d;
      gap_q        <= gap_d;
      drain_q      <= drain_d;
      busy         <= busy_d;
      done         <= done_d;
      err          <= err_d;
      rd_en        <= rd_en_d;
      rd_row       <= rd_row_d;
      rd_col       <= rd_col_d;
      window_valid <= window_valid_d;
      window_new   <= window_new_d;
      out_count    <= out_count_d;
    end
  end

endmodule

// File: tb/tb_conv_window_sched.sv
// tb_conv_window_sched: directed bench for conv_window_sched with a column-count
// array model that returns one result per window from column K-1 onward.
module tb_conv_window_sched;

  localparam int unsigned K  = 3;
  localparam int unsigned DW = 7;
  localparam int unsigned PW = K * 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [DW-1:0]   cfg_width;
  logic [DW-1:0]   cfg_height;
  logic            stall;
  logic            busy, done, err, rd_en;
  logic [DW-1:0]   rd_row, rd_col;
  logic [PW-1:0]   rd_data = '0;
  logic            window_valid, window_new;
  logic [PW-1:0]   window;
  logic            conv_valid_in = 1'b0;
  logic [2*DW-1:0] out_count;

  conv_window_sched dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_width     (cfg_width),
    .cfg_height    (cfg_height),
    .stall         (stall),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .rd_en         (rd_en),
    .rd_row        (rd_row),
    .rd_col        (rd_col),
    .rd_data       (rd_data),
    .window_valid  (window_valid),
    .window_new    (window_new),
    .window        (window),
    .conv_valid_in (conv_valid_in),
    .out_count     (out_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Monitor / array model state (written only by the monitor).
  int              cyc = 0, n_rd = 0, n_win = 0, n_new = 0, n_done = 0, n_err = 0;
  int              n_busy = 0, n_viol = 0, done_cyc = 0, colidx = 0;
  int              log_row[256], log_col[256], rd_cyc[256], new_idx[256];
  logic [2*DW-1:0] done_oc = '0;
  logic            done_busy = 1'b0;
  logic [PW-1:0]   pend = '0;

  // Stimulus-side snapshots.
  bit model_en = 1'b1;
  int b_rd, b_win, b_new, b_done, b_err, b_busy, b_viol, st_cyc;

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (window_valid) begin
      check("window_data", 128'(window), 128'(pend));
      n_win++;
      if (window_new) begin
        if (n_new < 256) new_idx[n_new] = n_win;
        n_new++;
        colidx = 0;
      end else begin
        colidx++;
      end
    end
    if (window_new) check("window_new_with_valid", 128'(window_valid), 128'(1));
    conv_valid_in = model_en && window_valid && (colidx >= int'(K) - 1);
    if (rd_en) begin
      if (n_rd < 256) begin
        log_row[n_rd] = int'(rd_row);
        log_col[n_rd] = int'(rd_col);
        rd_cyc[n_rd]  = cyc;
      end
      pend    = PW'({32'(rd_row), 32'(rd_col), 32'hC0DE_0000 + 32'(n_rd)});
      rd_data = pend;
      n_rd++;
    end
    if (stall && rd_en) n_viol++;
    if (busy) n_busy++;
    if (done) begin
      n_done++;
      done_cyc  = cyc;
      done_oc   = out_count;
      done_busy = busy;
    end
    if (err) n_err++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic snap();
    b_rd = n_rd; b_win = n_win; b_new = n_new; b_done = n_done;
    b_err = n_err; b_busy = n_busy; b_viol = n_viol;
  endtask

  task automatic launch(input int w, input int h);
    cfg_width  = DW'(w);
    cfg_height = DW'(h);
    start      = 1'b1;
    st_cyc     = cyc;
    step();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (n_done == b_done && n < 2000) begin
      step();
      n++;
    end
    check(tag, 128'(n_done - b_done), 128'(1));
  endtask

  task automatic wait_reads(input int k);
    int n = 0;
    while ((n_rd - b_rd) < k && n < 500) begin
      step();
      n++;
    end
    check("reads_reached", 128'((n_rd - b_rd) >= k), 128'(1));
  endtask

  task automatic check_seq(input string tag, input int w, input int rows);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < w; c++) begin
        check({tag, "_row"}, 128'(log_row[b_rd + r*w + c]), 128'(r));
        check({tag, "_col"}, 128'(log_col[b_rd + r*w + c]), 128'(c));
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_done"}, 128'(done), 128'(0));
    check({tag, "_err"}, 128'(err), 128'(0));
    check({tag, "_rd_en"}, 128'(rd_en), 128'(0));
    check({tag, "_rd_row"}, 128'(rd_row), 128'(0));
    check({tag, "_rd_col"}, 128'(rd_col), 128'(0));
    check({tag, "_wvalid"}, 128'(window_valid), 128'(0));
    check({tag, "_wnew"}, 128'(window_new), 128'(0));
    check({tag, "_out_count"}, 128'(out_count), 128'(0));
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    stall      = 1'b0;
    cfg_width  = '0;
    cfg_height = '0;
    repeat (3) step();
    check_idle_outputs("reset");
    rst = 1'b0;
    step();

    // Nominal 5x4 pass: two rows of five reads, six results.
    snap();
    launch(5, 4);
    wait_done("t1_done");
    step();
    check("t1_reads", 128'(n_rd - b_rd), 128'(10));
    check_seq("t1", 5, 2);
    check("t1_windows", 128'(n_win - b_win), 128'(10));
    check("t1_new_count", 128'(n_new - b_new), 128'(2));
    check("t1_new_first", 128'(new_idx[b_new] - b_win), 128'(1));
    check("t1_new_second", 128'(new_idx[b_new + 1] - b_win), 128'(6));
    check("t1_row0_span", 128'(rd_cyc[b_rd + 4] - rd_cyc[b_rd]), 128'(4));
    check("t1_row_gap", 128'(rd_cyc[b_rd + 5] - rd_cyc[b_rd + 4]), 128'(4));
    check("t1_out_count", 128'(done_oc), 128'(6));
    check("t1_err", 128'(n_err - b_err), 128'(0));
    check("t1_busy_at_done", 128'(done_busy), 128'(0));
    check("t1_busy_seen", 128'((n_busy - b_busy) > 0), 128'(1));

    // Stall for three cycles right after the first read of row 0.
    snap();
    launch(5, 4);
    wait_reads(1);
    stall = 1'b1;
    repeat (3) step();
    stall = 1'b0;
    wait_done("t2_done");
    step();
    check("t2_rd_during_stall", 128'(n_viol - b_viol), 128'(0));
    check("t2_reads", 128'(n_rd - b_rd), 128'(10));
    check_seq("t2", 5, 2);
    check("t2_windows", 128'(n_win - b_win), 128'(10));
    check("t2_stall_span", 128'(rd_cyc[b_rd + 1] - rd_cyc[b_rd]), 128'(4));
    check("t2_out_count", 128'(done_oc), 128'(6));
    check("t2_err", 128'(n_err - b_err), 128'(0));

    // Illegal width, then illegal height.
    snap();
    launch(2, 4);
    step();
    check("t3w_done", 128'(n_done - b_done), 128'(1));
    check("t3w_err", 128'(n_err - b_err), 128'(1));
    check("t3w_latency", 128'(done_cyc - st_cyc), 128'(1));
    check("t3w_busy", 128'(n_busy - b_busy), 128'(0));
    check("t3w_reads", 128'(n_rd - b_rd), 128'(0));
    snap();
    launch(5, 65);
    step();
    check("t3h_done", 128'(n_done - b_done), 128'(1));
    check("t3h_err", 128'(n_err - b_err), 128'(1));
    check("t3h_latency", 128'(done_cyc - st_cyc), 128'(1));
    check("t3h_busy", 128'(n_busy - b_busy), 128'(0));
    check("t3h_reads", 128'(n_rd - b_rd), 128'(0));

    // 3x3 with no results from the array: drain timeout.
    snap();
    model_en = 1'b0;
    launch(3, 3);
    wait_done("t4_done");
    step();
    model_en = 1'b1;
    check("t4_reads", 128'(n_rd - b_rd), 128'(3));
    check_seq("t4", 3, 1);
    check("t4_err", 128'(n_err - b_err), 128'(1));
    check("t4_timeout_latency", 128'(done_cyc - rd_cyc[b_rd + 2]), 128'(64));
    check("t4_out_count", 128'(done_oc), 128'(0));

    // Reset together with start in the middle of row 1, then a clean pass.
    snap();
    launch(5, 4);
    wait_reads(6);
    rst   = 1'b1;
    start = 1'b1;
    step();
    check_idle_outputs("t5_abort");
    check("t5_no_done", 128'(n_done - b_done), 128'(0));
    rst   = 1'b0;
    start = 1'b0;
    step();
    snap();
    launch(5, 4);
    wait_done("t5_done");
    step();
    check("t5_reads", 128'(n_rd - b_rd), 128'(10));
    check("t5_first_row", 128'(log_row[b_rd]), 128'(0));
    check("t5_first_col", 128'(log_col[b_rd]), 128'(0));
    check("t5_out_count", 128'(done_oc), 128'(6));
    check("t5_err", 128'(n_err - b_err), 128'(0));

    // Second start while busy with a different width is ignored.
    snap();
    launch(5, 4);
    wait_reads(2);
    cfg_width = DW'(8);
    start     = 1'b1;
    step();
    start     = 1'b0;
    wait_done("t6_done");
    repeat (4) step();
    check("t6_reads", 128'(n_rd - b_rd), 128'(10));
    check("t6_last_col", 128'(log_col[b_rd + 9]), 128'(4));
    check("t6_last_row", 128'(log_row[b_rd + 9]), 128'(1));
    check("t6_out_count", 128'(done_oc), 128'(6));
    check("t6_err", 128'(n_err - b_err), 128'(0));
    check("t6_single_done", 128'(n_done - b_done), 128'(1));
    check("t6_idle_after", 128'(busy), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_window_sched.md
Name: conv_window_sched

Overview:
- Sequences one feature-map pass through the convolution array: `start`/`busy`/`done` control, read-address generation for a column-banked feature SRAM, and `window`/`window_valid`/`window_new` generation.
- Each read returns one vertical column of KERNEL_SIZE pixels. The array accumulates KERNEL_SIZE consecutive columns into one output.
- The block counts returned results to detect completion, with a drain timeout.
- Sits between the top-level layer controller and the conv array / feature SRAM.

Parameters:
- KERNEL_SIZE, 3, kernel edge length; pixels per column read; columns accumulated per output.
- MAX_DIM, 64, largest legal feature-map width or height.
- ROW_GAP, 3, idle cycles inserted before every output row except the first, so the array pipeline drains.
- DRAIN_MAX, 64, cycles allowed in DRAIN before timeout.
- DW, $clog2(MAX_DIM+1), derived width of dimension and coordinate fields.

Ports:
- `clk`, in, 1, clock.
- `rst`, in, 1, reset: synchronous, active-high.
- `start`, in, 1, begin a pass with the current `cfg_*` values; sampled in IDLE only.
- `cfg_width`, in, DW, feature-map width W.
- `cfg_height`, in, DW, feature-map height H.
- `stall`, in, 1, downstream backpressure; no new read issued while high.
- `busy`, out, 1, high from accepted `start` until `done`.
- `done`, out, 1, one-cycle completion pulse.
- `err`, out, 1, one-cycle error pulse; coincident with `done`.
- `rd_en`, out, 1, SRAM column read strobe.
- `rd_row`, out, DW, top row of the requested column (output row index).
- `rd_col`, out, DW, requested column.
- `rd_data`, in, KERNEL_SIZE*32, column pixels; valid exactly 1 cycle after `rd_en`.
- `window_valid`, out, 1, `window` valid to the conv array.
- `window_new`, out, 1, first column of an output row; only ever high together with `window_valid`.
- `window`, out, KERNEL_SIZE*32, equals `rd_data` (combinational pass-through).
- `conv_valid_in`, in, 1, result strobe from the array (lane 0 `conv_valid`).
- `out_count`, out, 2*DW, results counted in the current pass.

Behaviour:
- Reset:
  - State goes to IDLE.
  - `busy`, `done`, `err`, `rd_en`, `window_valid`, `window_new` = 0.
  - `rd_row`, `rd_col`, `out_count` = 0.
  - `rst` mid-pass aborts immediately; no `done` is produced.
  - `rst` wins over a simultaneous `start`.
- State machine: IDLE, STREAM, GAP, DRAIN.
- IDLE, on `start`:
  - Config is legal when KERNEL_SIZE ≤ W ≤ MAX_DIM and KERNEL_SIZE ≤ H ≤ MAX_DIM.
  - Legal config: latch W and H, row=0, col=0, `out_count`=0, `busy`=1, go to STREAM.
  - Illegal config: next cycle `done`=1 and `err`=1 for one cycle; stay IDLE; `busy` stays 0.
- `start` while busy is ignored; the latched config is unaffected by later `cfg_*` changes.
- STREAM, each cycle with `stall`=0:
  - Drive `rd_en`=1, `rd_row`=row, `rd_col`=col.
  - If col==W-1 then col=0 and row++; otherwise col++.
  - After issuing (row=H-KERNEL_SIZE, col=W-1): go to DRAIN.
  - Otherwise, after issuing col=W-1: go to GAP.
- STREAM with `stall`=1: `rd_en`=0 and all counters hold. A read already issued is still delivered.
- GAP: `rd_en`=0 for ROW_GAP cycles (`stall` is ignored here), then back to STREAM.
- Window timing:
  - `window_valid` = `rd_en` registered by one cycle.
  - `window_new` = (`rd_en` & `rd_col`==0) registered by one cycle.
  - `window_new` therefore appears on the first window of every row, including row 0.
- Total reads per pass: (H-KERNEL_SIZE+1)*W.
- Result counting: every `conv_valid_in`=1 while `busy` increments `out_count`, in any state. `out_count` holds after `done` until the next accepted `start`.
- Expected results E = (H-KERNEL_SIZE+1)*(W-KERNEL_SIZE+1), computed at 2*DW bits.
- DRAIN, normal exit: when `out_count` reaches E (including a count reached before DRAIN), next cycle pulse `done`, drop `busy`, go to IDLE.
- DRAIN, timeout: after DRAIN_MAX cycles without reaching E, pulse `done`+`err`, drop `busy`, go to IDLE.
- Overcount: extra `conv_valid_in` pulses beyond E while busy still increment `out_count`; this is not an error.

Test Plan:
- K=3, W=5, H=4, stall=0, array model returns 3 results per row → 10 reads, `rd_row` 0×5 then 1×5, `rd_col` 0..4 twice; `window_new` on reads 1 and 6; 3 gap cycles between rows; `done` with `out_count`=6, `err`=0.
- Same config with `stall`=1 for cycles 2-4 of row 0 → no `rd_en` during stall; address sequence unchanged; read in flight at stall onset still yields `window_valid`.
- `start` with W=2 (or H=65) → `done`+`err` one cycle later, `busy` never set, `rd_en` never asserted.
- K=3, W=H=3 with the array returning no results → one row of 3 reads, then DRAIN; `done`+`err` exactly 64 cycles after DRAIN entry, `out_count`=0.
- `rst` asserted mid-row-1 together with `start` → all outputs 0 next cycle, IDLE; a later `start` restarts at row 0, col 0 with `out_count`=0.
- Second `start` pulse while busy, with `cfg_width` changed → ignored; pass completes with the original W.
